load_cache_responder: RTL and testbench



---
 rtl/load_cache_responder.sv | 147 ++++++++++++++
 tb/tb_load_cache_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/load_cache_responder.sv
// Direct-mapped, word-granular read cache serving the load read port.
// Misses are filled from backing memory; store invalidates keep lines coherent.
module load_cache_responder #(
    parameter int WORD_SIZE  = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_read_enable,
    input  logic [WORD_SIZE-1:0] c_ptr,
    output logic [WORD_SIZE-1:0] c_out,
    output logic                 c_hit,
    output logic                 c_ready,
    output logic                 c_busy,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_valid,
    input  logic                 inv_enable,
    input  logic [WORD_SIZE-1:0] inv_ptr
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state_q;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       valid_d;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [WORD_SIZE-1:0]   data_q [LINES];
    logic [WORD_SIZE-1:0]   c_out_q;
    logic                   c_hit_q;
    logic                   c_ready_q;
    logic                   c_busy_q;
    logic                   mem_req_q;
    logic [WORD_SIZE-1:0]   mem_addr_q;

    logic [INDEX_BITS-1:0]  rd_idx_s;
    logic [TAG_BITS-1:0]    rd_tag_s;
    logic [INDEX_BITS-1:0]  fill_idx_s;
    logic [TAG_BITS-1:0]    fill_tag_s;
    logic [INDEX_BITS-1:0]  inv_idx_s;
    logic [TAG_BITS-1:0]    inv_tag_s;
    logic                   lookup_hit_s;
    logic                   fill_en_s;
    logic                   inv_match_s;
    logic                   inv_fill_s;

    assign rd_idx_s     = c_ptr[INDEX_BITS-1:0];
    assign rd_tag_s     = c_ptr[WORD_SIZE-1:INDEX_BITS];
    assign fill_idx_s   = mem_addr_q[INDEX_BITS-1:0];
    assign fill_tag_s   = mem_addr_q[WORD_SIZE-1:INDEX_BITS];
    assign inv_idx_s    = inv_ptr[INDEX_BITS-1:0];
    assign inv_tag_s    = inv_ptr[WORD_SIZE-1:INDEX_BITS];
    assign lookup_hit_s = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
    assign fill_en_s    = (state_q == MISS) && mem_valid;
    assign inv_match_s  = inv_enable && valid_q[inv_idx_s] && (tag_q[inv_idx_s] == inv_tag_s);
    assign inv_fill_s   = inv_enable && (inv_ptr == mem_addr_q);

    // Valid-bit update: invalidate first, then a fill (which stays invalid if the same word is invalidated now)
    always_comb begin
        valid_d = valid_q;
        if (inv_match_s) begin
            valid_d[inv_idx_s] = 1'b0;
        end else begin
            valid_d = valid_d;
        end
        if (fill_en_s) begin
            valid_d[fill_idx_s] = !inv_fill_s;
        end else begin
            valid_d = valid_d;
        end
    end

    // Tag and data storage; written only by a fill, never reset
    always_ff @(posedge clk) begin
        if (fill_en_s) begin
            tag_q[fill_idx_s]  <= fill_tag_s;
            data_q[fill_idx_s] <= mem_data;
        end
    end

    // Control FSM with registered response and memory-request outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            c_out_q    <= '0;
            c_hit_q    <= 1'b0;
            c_ready_q  <= 1'b0;
            c_busy_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            valid_q   <= valid_d;
            c_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (c_read_enable) begin
                        if (lookup_hit_s) begin
                            c_out_q   <= data_q[rd_idx_s];
                            c_hit_q   <= 1'b1;
                            c_ready_q <= 1'b1;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= c_ptr;
                            c_busy_q   <= 1'b1;
                            state_q    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_valid) begin
                        c_out_q   <= mem_data;
                        c_hit_q   <= 1'b0;
                        c_ready_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= RESPOND;
                    end
                end
                RESPOND: begin
                    c_busy_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    c_busy_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign c_out    = c_out_q;
    assign c_hit    = c_hit_q;
    assign c_ready  = c_ready_q;
    assign c_busy   = c_busy_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_load_cache_responder.sv
// Directed bench for load_cache_responder: misses, hits, conflicts, invalidates and reset mid-miss.
module tb_load_cache_responder;

    logic        clk;
    logic        reset;
    logic        c_read_enable;
    logic [31:0] c_ptr;
    logic [31:0] c_out;
    logic        c_hit;
    logic        c_ready;
    logic        c_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        inv_enable;
    logic [31:0] inv_ptr;

    int n_cmp = 0;
    int n_err = 0;

    load_cache_responder #(.WORD_SIZE(32), .INDEX_BITS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .c_read_enable (c_read_enable),
        .c_ptr         (c_ptr),
        .c_out         (c_out),
        .c_hit         (c_hit),
        .c_ready       (c_ready),
        .c_busy        (c_busy),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_valid     (mem_valid),
        .inv_enable    (inv_enable),
        .inv_ptr       (inv_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete read; on a miss memory answers 3 cycles after mem_req rises.
    // inv_same raises an invalidate of the same address on the lookup (hit) or fill (miss) edge.
    task automatic rd(input logic [31:0] a, input logic exp_hit,
                      input logic [31:0] d, input logic inv_same);
        c_ptr         = a;
        c_read_enable = 1'b1;
        inv_enable    = inv_same && exp_hit;
        inv_ptr       = a;
        step();
        inv_enable = 1'b0;
        if (exp_hit) begin
            c_read_enable = 1'b0;
            chk($sformatf("hit_ready@%h", a), {31'd0, c_ready}, 32'd1);
            chk($sformatf("hit_flag@%h", a), {31'd0, c_hit}, 32'd1);
            chk($sformatf("hit_data@%h", a), c_out, d);
            chk($sformatf("hit_noreq@%h", a), {31'd0, mem_req}, 32'd0);
        end else begin
            chk($sformatf("miss_req@%h", a), {31'd0, mem_req}, 32'd1);
            chk($sformatf("miss_addr@%h", a), mem_addr, a);
            chk($sformatf("miss_busy@%h", a), {31'd0, c_busy}, 32'd1);
            chk($sformatf("miss_noready@%h", a), {31'd0, c_ready}, 32'd0);
            step();
            step();
            chk($sformatf("miss_reqheld@%h", a), {31'd0, mem_req}, 32'd1);
            mem_data   = d;
            mem_valid  = 1'b1;
            inv_enable = inv_same;
            step();
            mem_valid     = 1'b0;
            inv_enable    = 1'b0;
            c_read_enable = 1'b0;
            chk($sformatf("fill_ready@%h", a), {31'd0, c_ready}, 32'd1);
            chk($sformatf("fill_flag@%h", a), {31'd0, c_hit}, 32'd0);
            chk($sformatf("fill_data@%h", a), c_out, d);
            chk($sformatf("fill_reqdrop@%h", a), {31'd0, mem_req}, 32'd0);
        end
        step();
        chk($sformatf("ready_pulse@%h", a), {31'd0, c_ready}, 32'd0);
        chk($sformatf("idle_busy@%h", a), {31'd0, c_busy}, 32'd0);
        chk($sformatf("out_hold@%h", a), c_out, d);
    endtask

    initial begin
        reset         = 1'b0;
        c_read_enable = 1'b0;
        c_ptr         = 32'd0;
        mem_data      = 32'd0;
        mem_valid     = 1'b0;
        inv_enable    = 1'b0;
        inv_ptr       = 32'd0;
        step();
        chk("rst_out", c_out, 32'd0);
        chk("rst_hit", {31'd0, c_hit}, 32'd0);
        chk("rst_ready", {31'd0, c_ready}, 32'd0);
        chk("rst_busy", {31'd0, c_busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        reset = 1'b1;
        step();

        rd(32'h24, 1'b0, 32'hDEADBEEF, 1'b0);
        rd(32'h24, 1'b1, 32'hDEADBEEF, 1'b0);

        rd(32'h14, 1'b0, 32'h11111111, 1'b0);
        rd(32'h24, 1'b0, 32'hDEADBEEF, 1'b0);
        rd(32'h24, 1'b1, 32'hDEADBEEF, 1'b0);

        rd(32'h30, 1'b0, 32'h30303030, 1'b0);
        inv_enable = 1'b1;
        inv_ptr    = 32'h30;
        step();
        inv_enable = 1'b0;
        rd(32'h30, 1'b0, 32'h33333333, 1'b0);
        inv_enable = 1'b1;
        inv_ptr    = 32'h40;
        step();
        inv_enable = 1'b0;
        rd(32'h30, 1'b1, 32'h33333333, 1'b0);

        rd(32'h50, 1'b0, 32'h50505050, 1'b1);
        rd(32'h50, 1'b0, 32'h55555555, 1'b0);
        rd(32'h50, 1'b1, 32'h55555555, 1'b1);
        rd(32'h50, 1'b0, 32'h5A5A5A5A, 1'b0);

        mem_data  = 32'hBAD0BAD0;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("stray_valid_ready", {31'd0, c_ready}, 32'd0);
        chk("stray_valid_busy", {31'd0, c_busy}, 32'd0);

        c_ptr         = 32'h60;
        c_read_enable = 1'b1;
        step();
        chk("mid_miss_req", {31'd0, mem_req}, 32'd1);
        c_read_enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, c_busy}, 32'd0);
        chk("mid_rst_out", c_out, 32'd0);
        chk("mid_rst_hit", {31'd0, c_hit}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        step();
        reset     = 1'b1;
        mem_data  = 32'h60606060;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("post_rst_noready", {31'd0, c_ready}, 32'd0);
        step();
        chk("post_rst_noready2", {31'd0, c_ready}, 32'd0);
        rd(32'h60, 1'b0, 32'h66666666, 1'b0);
        rd(32'h24, 1'b0, 32'hDEADBEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
